ieee80211_receiver: RTL and testbench
=====================================

Name: ieee80211_receiver

Overview:
- Bit-serial receive-side counterpart of the transmitter in the baseband chain.
- Recovers the frame from the serial line: detects the 12-bit all-ones preamble, captures the 24-bit unscrambled header and extracts its 12-bit LENGTH field.
- Descrambles the payload (seed 7'd111) and emits plain bits with a valid strobe.
- Declares the frame done after the computed bit count, then re-arms for the next preamble.

Parameters:
- PRE_LEN, 12, number of consecutive ones forming the preamble.
- HDR_LEN, 24, header bits following the preamble (sent unscrambled).
- SEED, 7'd111, descrambler initial state loaded at payload start.

Ports:
- Clk  in  1  single clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-low reset.
- Enable  in  1  receiver enable; low = synchronous return to IDLE.
- x  in  1  serial line bit, sampled every Clk.
- num_pads  in  3  pad bytes per frame; sampled at header end.
- y  out  1  descrambled payload bit.
- y_valid  out  1  y holds a payload bit this cycle.
- length  out  12  captured LENGTH field (bytes).
- hdr_valid  out  1  one-cycle pulse when the header is complete.
- frame_done  out  1  one-cycle pulse on the last payload bit.
- busy  out  1  high in HDR or DATA state.

Behaviour:
- Reset (Reset=0, async): state=IDLE; y=0, y_valid=0, length=0, hdr_valid=0, frame_done=0, busy=0; counters 0; descrambler state=SEED.
- Enable=0 at a Clk edge: same clear as reset, except it is synchronous.
- States: IDLE, PRE, HDR, DATA. All outputs are registered, with 1-cycle latency from sampling x.
- IDLE:
  - x=1 -> PRE with ones_cnt=1.
- PRE:
  - x=1 increments ones_cnt.
  - x=0 before ones_cnt reaches PRE_LEN -> IDLE, count cleared.
  - ones_cnt==PRE_LEN -> HDR. The next sampled bit is header bit 0 regardless of its value; a 13th one is not preamble.
- HDR:
  - Capture header bits 0..23 with hdr_cnt.
  - Bits 5..16 shift MSB-first into length.
  - On bit 23: hdr_valid=1 next cycle; latch num_pads.
  - Compute total = (length + 2 + num_pads) * 8 as 16-bit unsigned (max 32832, no overflow).
  - Load descrambler with SEED; enter DATA.
- DATA, per bit:
  - fb = s[6]^s[3]; y = x^fb; s <= {s[5:0], fb}.
  - y_valid=1; data_cnt increments.
  - When data_cnt == total-1: frame_done=1 with that bit; -> IDLE.
- length holds its value until the next header start; it clears at HDR entry.
- LENGTH=0 with num_pads=0 is still legal: 16 payload bits.
- busy=1 in HDR and DATA.
- x is ignored in DATA for preamble purposes; there is no resync mid-frame.
- Enable falling mid-frame aborts silently: no frame_done.
- Reset mid-frame has the same effect as an abort.

Optional Feature:
- Macro RX_BYTE_OUT_EN.
- Defined:
  - Extra outputs byte_out[7:0] and byte_valid.
  - Payload bits are assembled LSB-first.
  - byte_valid pulses one cycle after every 8th y_valid bit.
  - The byte register clears at DATA entry.
  - The final pulse coincides with frame_done+1.
- Undefined: ports absent; bit-serial output only.

Decomposition:
- Package ieee80211_pkg holds:
  - state enum (IDLE/PRE/HDR/DATA);
  - PRE_LEN/HDR_LEN defaults;
  - LEN_LSB=5, LEN_MSB_POS=16 header field positions;
  - SCR_SEED=7'd111 and tap positions 6/3 (shared with the transmitter's scrambler).
- Sub-module: descrambler.
  - 7-bit LFSR with load/enable, combinational out = in ^ (s[6]^s[3]).
  - Port-compatible with the existing Scrambler, so either can be cross-checked.

Test Plan:
- Reset low, then Enable=1, x=0 for 20 cycles -> state IDLE, busy=0, y_valid never asserts.
- 11 ones, 0, then 12 ones + header with LENGTH=12'h003, num_pads=0 -> first attempt rejected; hdr_valid pulses after bit 23; length=3; 40 payload bits with y_valid; frame_done on the 40th.
- Feed the transmitter's output (payload 0xA5, 0x3C, LENGTH=2) directly into x -> y sequence bit-exact with the original unscrambled input; frame_done after 32 bits.
- LENGTH=12'hFFF, num_pads=7 -> total=32832; counter does not wrap; frame_done exactly on bit 32832.
- Drop Enable at payload bit 10, then reassert and send a fresh frame -> no frame_done for the aborted frame; the second frame decodes correctly from seed 7'd111.
- With RX_BYTE_OUT_EN, payload bits 1,0,1,0,0,1,0,1 -> byte_out=8'hA5, byte_valid single pulse.

Source files
------------

// File: rtl/ieee80211_receiver_pkg.sv
// Shared definitions for the 802.11 baseband receive path: FSM states, frame geometry
// and scrambler constants common with the transmitter.
package ieee80211_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StHdr,
        StData
    } rx_state_e;

    localparam int unsigned PRE_LEN     = 12;
    localparam int unsigned HDR_LEN     = 24;
    localparam int unsigned LEN_LSB     = 5;
    localparam int unsigned LEN_MSB_POS = 16;

    localparam logic [6:0]  SCR_SEED   = 7'd111;
    localparam int unsigned SCR_TAP_HI = 6;
    localparam int unsigned SCR_TAP_LO = 3;

    // Payload bit count: LENGTH bytes plus 2 service bytes plus pads, in bits.
    function automatic logic [15:0] frame_bits(logic [11:0] len, logic [2:0] pads);
        return ({4'd0, len} + 16'd2 + {13'd0, pads}) << 3;
    endfunction

endpackage

// File: rtl/ieee80211_receiver_if.sv
// Receiver line/strobe bundle. Optional byte outputs appear when RX_BYTE_OUT_EN is defined.
interface ieee80211_receiver_if;

    logic        Enable;
    logic        x;
    logic [2:0]  num_pads;
    logic        y;
    logic        y_valid;
    logic [11:0] length;
    logic        hdr_valid;
    logic        frame_done;
    logic        busy;

`ifdef RX_BYTE_OUT_EN
    logic [7:0]  byte_out;
    logic        byte_valid;

    modport master (
        output Enable, x, num_pads,
        input  y, y_valid, length, hdr_valid, frame_done, busy, byte_out, byte_valid
    );
    modport slave (
        input  Enable, x, num_pads,
        output y, y_valid, length, hdr_valid, frame_done, busy, byte_out, byte_valid
    );
`else
    modport master (
        output Enable, x, num_pads,
        input  y, y_valid, length, hdr_valid, frame_done, busy
    );
    modport slave (
        input  Enable, x, num_pads,
        output y, y_valid, length, hdr_valid, frame_done, busy
    );
`endif

endinterface

// File: rtl/ieee80211_receiver_descrambler.sv
// Additive 7-bit LFSR descrambler (x^7 + x^4 + 1); same ports and taps as the TX scrambler.
module ieee80211_receiver_descrambler
    import ieee80211_pkg::*;
#(
    parameter logic [6:0] Seed = SCR_SEED
) (
    input  logic Clk,
    input  logic Reset,
    input  logic load_i,
    input  logic en_i,
    input  logic din_i,
    output logic dout_o
);

    logic [6:0] s_q, s_d;
    logic       fb;

    assign fb     = s_q[SCR_TAP_HI] ^ s_q[SCR_TAP_LO];
    assign dout_o = din_i ^ fb;

    always_comb begin
        s_d = s_q;
        if (load_i) begin
            s_d = Seed;
        end else if (en_i) begin
            s_d = {s_q[5:0], fb};
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            s_q <= Seed;
        end else begin
            s_q <= s_d;
        end
    end

endmodule

// File: rtl/ieee80211_receiver.sv
// Bit-serial 802.11 receiver: preamble detect, header/LENGTH capture, payload descramble.
// Optional byte assembly output enabled by defining RX_BYTE_OUT_EN.
module ieee80211_receiver
#(
    parameter int unsigned PreLen = ieee80211_pkg::PRE_LEN,
    parameter int unsigned HdrLen = ieee80211_pkg::HDR_LEN,
    parameter logic [6:0]  Seed   = ieee80211_pkg::SCR_SEED
) (
    input  logic                 Clk,
    input  logic                 Reset,
    ieee80211_receiver_if.slave  rx_bus
);
    import ieee80211_pkg::*;

    localparam int unsigned OnesW = $clog2(PreLen);
    localparam int unsigned HdrW  = $clog2(HdrLen);

    rx_state_e         state_q, state_d;
    logic [OnesW-1:0]  ones_cnt_q, ones_cnt_d;
    logic [HdrW-1:0]   hdr_cnt_q, hdr_cnt_d;
    logic [15:0]       data_cnt_q, data_cnt_d;
    logic [15:0]       total_q, total_d;
    logic [11:0]       length_q, length_d;
    logic              y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic              hdr_valid_q, hdr_valid_d;
    logic              frame_done_q, frame_done_d;
    logic              scr_load, scr_en, scr_out;
    logic              hdr_last;

    ieee80211_receiver_descrambler #(
        .Seed (Seed)
    ) u_descrambler (
        .Clk    (Clk),
        .Reset  (Reset),
        .load_i (scr_load),
        .en_i   (scr_en),
        .din_i  (rx_bus.x),
        .dout_o (scr_out)
    );

    assign hdr_last = (state_q == StHdr) && (hdr_cnt_q == HdrW'(HdrLen - 1));

    always_comb begin
        state_d      = state_q;
        ones_cnt_d   = ones_cnt_q;
        hdr_cnt_d    = hdr_cnt_q;
        data_cnt_d   = data_cnt_q;
        total_d      = total_q;
        length_d     = length_q;
        y_d          = 1'b0;
        y_valid_d    = 1'b0;
        hdr_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        scr_load     = 1'b0;
        scr_en       = 1'b0;

        if (!rx_bus.Enable) begin
            state_d    = StIdle;
            ones_cnt_d = '0;
            hdr_cnt_d  = '0;
            data_cnt_d = '0;
            total_d    = '0;
            length_d   = '0;
            scr_load   = 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (rx_bus.x) begin
                        state_d    = StPre;
                        ones_cnt_d = OnesW'(1);
                    end
                end
                StPre: begin
                    if (!rx_bus.x) begin
                        state_d    = StIdle;
                        ones_cnt_d = '0;
                    end else if (ones_cnt_q == OnesW'(PreLen - 1)) begin
                        // Preamble complete on this one; the next bit is header bit 0.
                        state_d    = StHdr;
                        ones_cnt_d = '0;
                        hdr_cnt_d  = '0;
                        length_d   = '0;
                    end else begin
                        ones_cnt_d = ones_cnt_q + OnesW'(1);
                    end
                end
                StHdr: begin
                    if (hdr_cnt_q >= HdrW'(LEN_LSB) && hdr_cnt_q <= HdrW'(LEN_MSB_POS)) begin
                        length_d = {length_q[10:0], rx_bus.x};
                    end
                    hdr_cnt_d = hdr_cnt_q + HdrW'(1);
                    if (hdr_last) begin
                        state_d     = StData;
                        hdr_cnt_d   = '0;
                        hdr_valid_d = 1'b1;
                        total_d     = frame_bits(length_d, rx_bus.num_pads);
                        data_cnt_d  = '0;
                        scr_load    = 1'b1;
                    end
                end
                StData: begin
                    y_d        = scr_out;
                    y_valid_d  = 1'b1;
                    scr_en     = 1'b1;
                    data_cnt_d = data_cnt_q + 16'd1;
                    if (data_cnt_q == total_q - 16'd1) begin
                        frame_done_d = 1'b1;
                        data_cnt_d   = '0;
                        state_d      = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q      <= StIdle;
            ones_cnt_q   <= '0;
            hdr_cnt_q    <= '0;
            data_cnt_q   <= '0;
            total_q      <= '0;
            length_q     <= '0;
            y_q          <= 1'b0;
            y_valid_q    <= 1'b0;
            hdr_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ones_cnt_q   <= ones_cnt_d;
            hdr_cnt_q    <= hdr_cnt_d;
            data_cnt_q   <= data_cnt_d;
            total_q      <= total_d;
            length_q     <= length_d;
            y_q          <= y_d;
            y_valid_q    <= y_valid_d;
            hdr_valid_q  <= hdr_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign rx_bus.y          = y_q;
    assign rx_bus.y_valid    = y_valid_q;
    assign rx_bus.length     = length_q;
    assign rx_bus.hdr_valid  = hdr_valid_q;
    assign rx_bus.frame_done = frame_done_q;
    assign rx_bus.busy       = (state_q == StHdr) || (state_q == StData);

`ifdef RX_BYTE_OUT_EN
    logic [7:0] byte_q, byte_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic       byte_valid_q, byte_valid_d;

    // Consumes the registered bit stream, so each byte lands one cycle after its 8th bit.
    always_comb begin
        byte_d       = byte_q;
        bcnt_d       = bcnt_q;
        byte_valid_d = 1'b0;
        if (!rx_bus.Enable || hdr_last) begin
            byte_d = '0;
            bcnt_d = '0;
        end else if (y_valid_q) begin
            byte_d       = {y_q, byte_q[7:1]};
            bcnt_d       = bcnt_q + 3'd1;
            byte_valid_d = (bcnt_q == 3'd7);
        end
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            byte_q       <= '0;
            bcnt_q       <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            byte_q       <= byte_d;
            bcnt_q       <= bcnt_d;
            byte_valid_q <= byte_valid_d;
        end
    end

    assign rx_bus.byte_out   = byte_q;
    assign rx_bus.byte_valid = byte_valid_q;
`endif

endmodule

// File: tb/tb_ieee80211_receiver.sv
// Self-checking bench: frames are built by a transmitter model (preamble, header, scrambled
// payload) and the receiver output is compared against the original plain payload.
module tb_ieee80211_receiver;

    logic Clk = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    ieee80211_receiver_if rx_bus ();

    ieee80211_receiver dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .rx_bus (rx_bus)
    );

    int n_vec = 0;
    int n_err = 0;
    bit pay_q[$];

    task automatic tick(input logic b);
        rx_bus.x = b;
        @(posedge Clk);
        #1;
    endtask

    // Transmit one frame and check the receiver. abort_at >= 0 drops Enable on that payload bit.
    task automatic run_frame(input logic [11:0] len, input logic [2:0] pads, input int abort_at);
        int         total;
        logic [23:0] hdr;
        logic [6:0] s;
        logic       fb;
        logic       line;
        logic [7:0] eb;
        logic       exp_bv;
        total = (int'(len) + 2 + int'(pads)) * 8;
        while (pay_q.size() < total) pay_q.push_back(1'($urandom_range(0, 1)));
        hdr = 24'($urandom);
        for (int k = 0; k < 12; k++) hdr[5 + k] = len[11 - k];
        rx_bus.num_pads = pads;
        for (int k = 0; k < 12; k++) tick(1'b1);
        n_vec++;
        if (rx_bus.busy !== 1'b1) begin
            n_err++;
            $display("FAIL busy_after_preamble: got %b want 1", rx_bus.busy);
        end
        for (int k = 0; k < 24; k++) begin
            tick(hdr[k]);
            if (k == 22) begin
                n_vec++;
                if (rx_bus.hdr_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL hdr_valid_early: got %b want 0", rx_bus.hdr_valid);
                end
            end
        end
        n_vec++;
        if (rx_bus.hdr_valid !== 1'b1) begin
            n_err++;
            $display("FAIL hdr_valid: got %b want 1", rx_bus.hdr_valid);
        end
        n_vec++;
        if (rx_bus.length !== len) begin
            n_err++;
            $display("FAIL length: got %h want %h", rx_bus.length, len);
        end
        s = 7'd111;
        for (int i = 0; i < total; i++) begin
            fb   = s[6] ^ s[3];
            line = pay_q[i] ^ fb;
            s    = {s[5:0], fb};
            if (i == abort_at) rx_bus.Enable = 1'b0;
            tick(line);
            if (i == abort_at) begin
                n_vec++;
                if ({rx_bus.y_valid, rx_bus.frame_done, rx_bus.busy} !== 3'b000) begin
                    n_err++;
                    $display("FAIL abort_clear: got valid/done/busy=%b want 000",
                             {rx_bus.y_valid, rx_bus.frame_done, rx_bus.busy});
                end
                rx_bus.Enable = 1'b1;
                for (int k = 0; k < 5; k++) begin
                    tick(1'b0);
                    n_vec++;
                    if (rx_bus.frame_done !== 1'b0 || rx_bus.y_valid !== 1'b0) begin
                        n_err++;
                        $display("FAIL abort_quiet: got done=%b valid=%b want 0 0",
                                 rx_bus.frame_done, rx_bus.y_valid);
                    end
                end
                pay_q.delete();
                return;
            end
            n_vec++;
            if (rx_bus.y_valid !== 1'b1 || rx_bus.y !== pay_q[i]) begin
                n_err++;
                $display("FAIL payload bit %0d: got valid=%b y=%b want valid=1 y=%b",
                         i, rx_bus.y_valid, rx_bus.y, pay_q[i]);
            end
            n_vec++;
            if (rx_bus.frame_done !== (i == total - 1)) begin
                n_err++;
                $display("FAIL frame_done bit %0d of %0d: got %b want %b",
                         i, total, rx_bus.frame_done, (i == total - 1));
            end
`ifdef RX_BYTE_OUT_EN
            exp_bv = (i >= 8) && (i % 8 == 0);
            n_vec++;
            if (rx_bus.byte_valid !== exp_bv) begin
                n_err++;
                $display("FAIL byte_valid bit %0d: got %b want %b", i, rx_bus.byte_valid, exp_bv);
            end
            if (exp_bv) begin
                for (int k = 0; k < 8; k++) eb[k] = pay_q[i - 8 + k];
                n_vec++;
                if (rx_bus.byte_out !== eb) begin
                    n_err++;
                    $display("FAIL byte_out bit %0d: got %h want %h", i, rx_bus.byte_out, eb);
                end
            end
`endif
        end
        tick(1'b0);
        n_vec++;
        if ({rx_bus.y_valid, rx_bus.frame_done, rx_bus.busy} !== 3'b000) begin
            n_err++;
            $display("FAIL post_frame: got valid/done/busy=%b want 000",
                     {rx_bus.y_valid, rx_bus.frame_done, rx_bus.busy});
        end
`ifdef RX_BYTE_OUT_EN
        for (int k = 0; k < 8; k++) eb[k] = pay_q[total - 8 + k];
        n_vec++;
        if (rx_bus.byte_valid !== 1'b1 || rx_bus.byte_out !== eb) begin
            n_err++;
            $display("FAIL last_byte: got valid=%b byte=%h want 1 %h",
                     rx_bus.byte_valid, rx_bus.byte_out, eb);
        end
`endif
        pay_q.delete();
    endtask

    task automatic test_reset();
        rx_bus.Enable   = 1'b0;
        rx_bus.x        = 1'b0;
        rx_bus.num_pads = 3'd0;
        #2 Reset = 1'b0;
        #1;
        n_vec++;
        if ({rx_bus.y, rx_bus.y_valid, rx_bus.length, rx_bus.hdr_valid, rx_bus.frame_done,
             rx_bus.busy} !== 17'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got y=%b v=%b len=%h hv=%b fd=%b busy=%b want all 0",
                     rx_bus.y, rx_bus.y_valid, rx_bus.length, rx_bus.hdr_valid,
                     rx_bus.frame_done, rx_bus.busy);
        end
        @(negedge Clk);
        Reset         = 1'b1;
        rx_bus.Enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1'b0);
            n_vec++;
            if (rx_bus.busy !== 1'b0 || rx_bus.y_valid !== 1'b0) begin
                n_err++;
                $display("FAIL idle_zero cycle %0d: got busy=%b valid=%b want 0 0",
                         i, rx_bus.busy, rx_bus.y_valid);
            end
        end
    endtask

    task automatic test_false_preamble();
        for (int i = 0; i < 11; i++) tick(1'b1);
        tick(1'b0);
        tick(1'b0);
        n_vec++;
        if (rx_bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL short_preamble: got busy=%b want 0", rx_bus.busy);
        end
        run_frame(12'h003, 3'd0, -1);
    endtask

    task automatic test_loopback();
        logic [7:0] bytes [4];
        bytes[0] = 8'hA5;
        bytes[1] = 8'h3C;
        bytes[2] = 8'h00;
        bytes[3] = 8'h00;
        for (int b = 0; b < 4; b++)
            for (int k = 0; k < 8; k++) pay_q.push_back(bytes[b][k]);
        run_frame(12'h002, 3'd0, -1);
    endtask

    task automatic test_len_zero();
        run_frame(12'h000, 3'd0, -1);
    endtask

    task automatic test_max_frame();
        run_frame(12'hFFF, 3'd7, -1);
    endtask

    task automatic test_abort();
        run_frame(12'h004, 3'd1, 10);
        run_frame(12'h005, 3'd2, -1);
    endtask

    task automatic test_reset_midframe();
        for (int i = 0; i < 12; i++) tick(1'b1);
        for (int i = 0; i < 10; i++) tick(1'($urandom_range(0, 1)));
        #2 Reset = 1'b0;
        #1;
        n_vec++;
        if (rx_bus.busy !== 1'b0 || rx_bus.length !== 12'd0) begin
            n_err++;
            $display("FAIL async_reset_midframe: got busy=%b len=%h want 0 000",
                     rx_bus.busy, rx_bus.length);
        end
        @(negedge Clk);
        Reset = 1'b1;
        tick(1'b0);
        run_frame(12'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), -1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick(1'b0);
            run_frame(12'($urandom_range(0, 20)), 3'($urandom_range(0, 7)), -1);
        end
    endtask

    initial begin
        test_reset();
        test_false_preamble();
        test_loopback();
        test_len_zero();
        test_max_frame();
        test_abort();
        test_reset_midframe();
        test_random_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
